// File: rtl/led_status_pkg.sv
// Shared encodings for the status LED arbiter: source display modes,
// blink-code pattern states and pattern timing constants.
package led_status_pkg;

  localparam logic [1:0] MODE_ON   = 2'b00;
  localparam logic [1:0] MODE_SLOW = 2'b01;
  localparam logic [1:0] MODE_FAST = 2'b10;
  localparam logic [1:0] MODE_CODE = 2'b11;

  typedef enum logic [1:0] {
    P_ON  = 2'd0,
    P_OFF = 2'd1,
    P_GAP = 2'd2
  } pat_state_t;

  localparam int unsigned SLOW_TICKS  = 5;
  localparam int unsigned PULSE_TICKS = 2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/led_pattern_gen.sv
// Tick prescaler and LED pattern generator (steady, slow, fast, N-pulse code).
// restart reloads everything and starts the pattern in its lit phase.
module led_pattern_gen
  import led_status_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 10,
  parameter int unsigned GAP_TICKS = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       restart,
  input  logic [1:0] mode,
  input  logic [2:0] code,
  output logic       LED,
  output logic       tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = $clog2(max3(SLOW_TICKS, PULSE_TICKS, GAP_TICKS) + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] SLOW_LAST  = CW'(SLOW_TICKS - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_TICKS - 1);

  logic [PW-1:0] presc;
  logic [CW-1:0] cnt;
  logic [2:0]    pulse;
  pat_state_t    state;

  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      cnt   <= '0;
      pulse <= '0;
      state <= P_ON;
      LED   <= 1'b0;
    end else if (!enable) begin
      presc <= '0;
      cnt   <= '0;
      pulse <= '0;
      state <= P_ON;
      LED   <= 1'b0;
    end else if (restart) begin
      presc <= '0;
      cnt   <= '0;
      pulse <= 3'd1;
      state <= P_ON;
      LED   <= (mode != MODE_CODE) || (code != 3'd0);
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        case (mode)
          MODE_ON: LED <= 1'b1;
          MODE_SLOW: begin
            if (cnt == SLOW_LAST) begin
              cnt <= '0;
              LED <= ~LED;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          MODE_FAST: LED <= ~LED;
          default: begin
            if (code == 3'd0) begin
              LED <= 1'b0;
            end else begin
              case (state)
                P_ON: begin
                  if (cnt == PULSE_LAST) begin
                    cnt   <= '0;
                    LED   <= 1'b0;
                    state <= (pulse >= code) ? P_GAP : P_OFF;
                  end else begin
                    cnt <= cnt + CW'(1);
                  end
                end
                P_OFF: begin
                  if (cnt == PULSE_LAST) begin
                    cnt   <= '0;
                    LED   <= 1'b1;
                    pulse <= pulse + 3'd1;
                    state <= P_ON;
                  end else begin
                    cnt <= cnt + CW'(1);
                  end
                end
                P_GAP: begin
                  if (cnt == GAP_LAST) begin
                    cnt   <= '0;
                    LED   <= 1'b1;
                    pulse <= 3'd1;
                    state <= P_ON;
                  end else begin
                    cnt <= cnt + CW'(1);
                  end
                end
                default: state <= P_ON;
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/led_status_arbiter.sv
// Fixed-priority arbiter sharing the board status LED between status sources,
// with a minimum hold time before preemption or mode changes take effect.
module led_status_arbiter
  import led_status_pkg::*;
#(
  parameter int unsigned CLOCK_SPEED    = 12_500_000,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TICK_DIV       = CLOCK_SPEED / 10,
  parameter int unsigned MIN_HOLD_TICKS = 10,
  parameter int unsigned GAP_TICKS      = 10
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [2*NUM_REQ-1:0]   mode,
  input  logic [3*NUM_REQ-1:0]   code,
  output logic                   LED,
  output logic                   active,
  output logic [2:0]             grant_idx
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_GRANTED = 1'b1;

  localparam int unsigned   HW       = (MIN_HOLD_TICKS > 0) ? $clog2(MIN_HOLD_TICKS + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD_TICKS);

  logic [0:0]    state, state_nxt;
  logic [1:0]    lat_mode, mode_nxt;
  logic [2:0]    lat_code, code_nxt;
  logic [2:0]    idx_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          hold_done;

  logic          any_req;
  logic [2:0]    win_idx;
  logic [1:0]    win_mode;
  logic [2:0]    win_code;
  logic          holder_req;
  logic          do_grant;
  logic          restart;
  logic          gen_enable;
  logic          tick;

  always_comb begin
    any_req    = 1'b0;
    win_idx    = '0;
    win_mode   = MODE_ON;
    win_code   = '0;
    holder_req = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req[i] && !any_req) begin
        any_req  = 1'b1;
        win_idx  = 3'(i);
        win_mode = mode[2*i +: 2];
        win_code = code[3*i +: 3];
      end
      if (3'(i) == grant_idx) holder_req = req[i];
    end
  end

  // Hold counts the tick landing on this edge, so preemption happens exactly on the expiring tick.
  assign hold_nxt  = (tick && hold_cnt != HOLD_MAX) ? hold_cnt + HW'(1) : hold_cnt;
  assign hold_done = (hold_nxt == HOLD_MAX);

  always_comb begin
    do_grant  = 1'b0;
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (any_req) do_grant = 1'b1;
      end
      default: begin
        if (!holder_req) begin
          if (any_req) do_grant = 1'b1;
          else         state_nxt = S_IDLE;
        end else if (hold_done && (win_idx != grant_idx || win_mode != lat_mode ||
                                   win_code != lat_code)) begin
          do_grant = 1'b1;
        end
      end
    endcase
    if (do_grant) state_nxt = S_GRANTED;
  end

  assign restart    = do_grant;
  assign idx_nxt    = do_grant ? win_idx : grant_idx;
  assign mode_nxt   = do_grant ? win_mode : lat_mode;
  assign code_nxt   = do_grant ? win_code : lat_code;
  assign gen_enable = (state_nxt == S_GRANTED);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      grant_idx <= '0;
      active    <= 1'b0;
      lat_mode  <= MODE_ON;
      lat_code  <= '0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      grant_idx <= idx_nxt;
      active    <= (state_nxt == S_GRANTED);
      lat_mode  <= mode_nxt;
      lat_code  <= code_nxt;
      hold_cnt  <= restart ? '0 : hold_nxt;
    end
  end

  // Next-cycle grant/mode feed the generator so LED updates on the same edge as grant_idx.
  led_pattern_gen #(
    .TICK_DIV (TICK_DIV),
    .GAP_TICKS(GAP_TICKS)
  ) u_pattern (
    .clock  (clock),
    .reset_n(reset_n),
    .enable (gen_enable),
    .restart(restart),
    .mode   (mode_nxt),
    .code   (code_nxt),
    .LED    (LED),
    .tick   (tick)
  );

endmodule

// File: tb/tb_led_status_arbiter.sv
// Directed bench for led_status_arbiter with a queue scoreboard of expected results.
module tb_led_status_arbiter;
  import led_status_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [7:0]  mode;
  logic [11:0] code;
  logic        LED;
  logic        active;
  logic [2:0]  grant_idx;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    logic [31:0] mask;
  } sb_t;

  sb_t sb[$];

  led_status_arbiter #(
    .CLOCK_SPEED   (100),
    .NUM_REQ       (4),
    .MIN_HOLD_TICKS(10),
    .GAP_TICKS     (10)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req      (req),
    .mode     (mode),
    .code     (code),
    .LED      (LED),
    .active   (active),
    .grant_idx(grant_idx)
  );

  always #5 clock = ~clock;

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_src(input int unsigned i, input logic [1:0] m, input logic [2:0] c);
    mode[2*i +: 2] = m;
    code[3*i +: 3] = c;
  endtask

  task automatic compare_head(input logic [31:0] obs);
    sb_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h required=an expected entry", obs);
    end else begin
      e = sb.pop_front();
      assert ((obs & e.mask) === (e.exp & e.mask)) else begin
        errors++;
        $error("FAIL %s observed=%0h required=%0h (mask %0h)", e.tag, obs & e.mask,
               e.exp & e.mask, e.mask);
      end
    end
  endtask

  // Packs {LED, active, grant_idx}; grant_idx is ignored when chk_idx=0.
  task automatic expect_out(input string tag, input logic led, input logic act,
                            input logic [2:0] idx, input bit chk_idx);
    sb_t e;
    e.tag  = tag;
    e.exp  = {27'd0, led, act, idx};
    e.mask = chk_idx ? 32'h1f : 32'h18;
    sb.push_back(e);
  endtask

  task automatic check_out();
    compare_head({27'd0, LED, active, grant_idx});
  endtask

  // Expects LED to hold `level` for n consecutive cycles starting now.
  task automatic led_window(input string tag, input logic level, input int unsigned n);
    sb_t e;
    int unsigned hits;
    e.tag  = tag;
    e.exp  = n;
    e.mask = '1;
    sb.push_back(e);
    hits = 0;
    for (int unsigned k = 0; k < n; k++) begin
      if (LED === level) hits++;
      cyc(1);
    end
    compare_head(hits);
  endtask

  initial begin
    reset_n = 1'b0;
    req     = 4'b1111;
    mode    = '0;
    code    = '0;
    cyc(3);
    expect_out("reset_state", 1'b0, 1'b0, 3'd0, 1'b1);
    check_out();

    reset_n = 1'b1;
    expect_out("grant_src0_after_reset", 1'b1, 1'b1, 3'd0, 1'b1);
    cyc(1);
    check_out();

    req = 4'b0000;
    expect_out("release_to_idle", 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1);
    check_out();

    // slow flash on source 2
    set_src(2, MODE_SLOW, 3'd0);
    req = 4'b0100;
    expect_out("slow_grant", 1'b1, 1'b1, 3'd2, 1'b1);
    cyc(1);
    check_out();
    led_window("slow_on1", 1'b1, 50);
    led_window("slow_off1", 1'b0, 50);
    led_window("slow_on2", 1'b1, 50);
    led_window("slow_off2", 1'b0, 50);
    expect_out("slow_still_held", 1'b1, 1'b1, 3'd2, 1'b1);
    check_out();

    // preemption held off until the hold time expires
    req = 4'b0000;
    expect_out("idle_before_fast", 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1);
    check_out();
    set_src(3, MODE_FAST, 3'd0);
    set_src(0, MODE_ON, 3'd0);
    req = 4'b1000;
    expect_out("fast_grant", 1'b1, 1'b1, 3'd3, 1'b1);
    cyc(1);
    check_out();
    led_window("fast_t0", 1'b1, 10);
    led_window("fast_t1", 1'b0, 10);
    led_window("fast_t2", 1'b1, 10);
    req = 4'b1001;
    led_window("fast_t3_held", 1'b0, 10);
    led_window("fast_t4", 1'b1, 10);
    led_window("fast_t5", 1'b0, 10);
    led_window("fast_t6", 1'b1, 10);
    led_window("fast_t7", 1'b0, 10);
    led_window("fast_t8", 1'b1, 10);
    led_window("fast_t9", 1'b0, 9);
    expect_out("hold_last_cycle", 1'b0, 1'b1, 3'd3, 1'b1);
    check_out();
    expect_out("preempt_at_tick10", 1'b1, 1'b1, 3'd0, 1'b1);
    cyc(1);
    check_out();

    // holder release with another source pending
    set_src(1, MODE_ON, 3'd0);
    req = 4'b1010;
    expect_out("release_to_src1", 1'b1, 1'b1, 3'd1, 1'b1);
    cyc(1);
    check_out();
    cyc(5);
    req = 4'b1001;
    expect_out("release_with_hp_request", 1'b1, 1'b1, 3'd0, 1'b1);
    cyc(1);
    check_out();

    // blink code 3
    req = 4'b0000;
    expect_out("idle_before_code3", 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1);
    check_out();
    set_src(0, MODE_CODE, 3'd3);
    req = 4'b0001;
    expect_out("code3_grant", 1'b1, 1'b1, 3'd0, 1'b1);
    cyc(1);
    check_out();
    led_window("code3_p1_on", 1'b1, 20);
    led_window("code3_p1_off", 1'b0, 20);
    led_window("code3_p2_on", 1'b1, 20);
    led_window("code3_p2_off", 1'b0, 20);
    led_window("code3_p3_on", 1'b1, 20);
    led_window("code3_gap", 1'b0, 100);
    led_window("code3_repeat_on", 1'b1, 20);
    led_window("code3_repeat_off", 1'b0, 20);

    // blink code 0: dark but active
    req = 4'b0000;
    expect_out("idle_before_code0", 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1);
    check_out();
    set_src(0, MODE_CODE, 3'd0);
    req = 4'b0001;
    expect_out("code0_grant", 1'b0, 1'b1, 3'd0, 1'b1);
    cyc(1);
    check_out();
    led_window("code0_dark", 1'b0, 40);
    expect_out("code0_still_active", 1'b0, 1'b1, 3'd0, 1'b1);
    check_out();

    // mode change by the holder deferred to hold expiry
    req = 4'b0000;
    expect_out("idle_before_modechange", 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1);
    check_out();
    set_src(0, MODE_SLOW, 3'd0);
    req = 4'b0001;
    expect_out("mc_grant", 1'b1, 1'b1, 3'd0, 1'b1);
    cyc(1);
    check_out();
    led_window("mc_slow_on", 1'b1, 40);
    set_src(0, MODE_ON, 3'd0);
    led_window("mc_change_ignored_on", 1'b1, 10);
    led_window("mc_change_ignored_off", 1'b0, 50);
    led_window("mc_steady_on", 1'b1, 60);
    expect_out("mc_active", 1'b1, 1'b1, 3'd0, 1'b1);
    check_out();

    // asynchronous reset mid-pattern
    #2;
    reset_n = 1'b0;
    #1;
    expect_out("async_reset", 1'b0, 1'b0, 3'd0, 1'b1);
    check_out();
    req = 4'b0000;
    cyc(2);
    reset_n = 1'b1;
    cyc(3);
    expect_out("post_reset_dark", 1'b0, 1'b0, 3'd0, 1'b1);
    check_out();
    set_src(2, MODE_SLOW, 3'd0);
    req = 4'b0100;
    expect_out("regrant_after_reset", 1'b1, 1'b1, 3'd2, 1'b1);
    cyc(1);
    check_out();
    led_window("regrant_slow_on", 1'b1, 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_status_arbiter.md
# led_status_arbiter

Shares the single board status LED between several status sources: bootloader idle, Ethernet activity, flash-programming progress and error reporting. Each source asks for a display mode; the block grants the LED to one source by fixed priority, enforces a minimum display time, and generates the selected pattern (steady, slow flash, fast flash, or an N-pulse blink code) from one shared tick prescaler. It sits between the bootloader control logic and the LED pin.

## Interface
- CLOCK_SPEED, 12_500_000, input clock frequency in Hz
- NUM_REQ, 4, number of requesters (2..8)
- TICK_DIV, CLOCK_SPEED/10, clocks per pattern tick (100 ms)
- MIN_HOLD_TICKS, 10, minimum ticks a grant is held before a higher-priority source may preempt it
- GAP_TICKS, 10, dark ticks after the last pulse of a blink code

- clock  in  1  system clock, all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  request per source; bit 0 has highest priority
- mode  in  2*NUM_REQ  per source [2i+1:2i]: 00 on, 01 slow, 10 fast, 11 code
- code  in  3*NUM_REQ  per source [3i+2:3i]: pulse count for code mode, 0..7
- LED  out  1  LED drive, high = lit
- active  out  1  a source currently holds the grant
- grant_idx  out  3  index of the holding source; meaningful when active=1

## Operation
- Reset values: LED=0, active=0, grant_idx=0, prescaler=0, hold and pattern counters=0, state IDLE.
- Arbitration runs every cycle. Winner = lowest index with req set.
- IDLE: no req set. On any req: grant the winner, latch its mode/code, active=1.
- GRANTED: re-grant, restarting the pattern, when any of:
  - the holder drops req: release at once; go to the new winner, or IDLE with LED=0, active=0 if none;
  - hold expired (≥ MIN_HOLD_TICKS ticks since grant) and the winner differs from the holder;
  - hold expired and the holder's mode/code differ from the latched values.
- Before hold expiry, a higher-priority req is not serviced, and mode/code changes by the holder are ignored.
- Every grant or restart clears the prescaler, hold counter and pattern counters, and starts the pattern in its ON phase.
- Patterns, in ticks:
  - on: LED=1 steady.
  - slow: LED toggles every 5 ticks (1 s period).
  - fast: LED toggles every tick (200 ms period).
  - code N (1..7): N pulses, each ON 2 ticks then OFF 2 ticks; the last pulse's OFF lasts GAP_TICKS; then repeat.
  - code 0: LED=0 steady, active=1.
- Pattern states: P_ON, P_OFF, P_GAP. Pulse counter counts 1..N and wraps to 1 when leaving P_GAP.
- Hold counter saturates at MIN_HOLD_TICKS and does not wrap.

## Timing
- One cycle from a req/mode edge to the registered LED, active and grant_idx outputs. All outputs are registered.
- Tick: prescaler counts 0..TICK_DIV-1 and pulses when it equals TICK_DIV-1. The first tick after a grant therefore arrives TICK_DIV cycles after the grant edge, so the first phase is full length.
- Simultaneous holder release and higher-priority request: the higher-priority source is granted the next cycle.
- reset_n asserted mid-pattern: all outputs return to reset values immediately (asynchronous), with no glitch back to the old pattern after release.

## Structure
- Shared package `led_status_pkg`: mode encodings (MODE_ON, MODE_SLOW, MODE_FAST, MODE_CODE), pattern state enum, SLOW_TICKS=5, PULSE_TICKS=2.
- Sub-module `led_pattern_gen`: owns the prescaler and pattern FSM. Inputs are restart, mode and code; outputs are LED and tick. The top level keeps arbitration and the hold counter.

## Test plan
Bench uses CLOCK_SPEED=100, so TICK_DIV=10.
- Reset: hold reset_n=0 with req=4'b1111 → LED=0, active=0, grant_idx=0. After release, source 0 is granted on the next edge.
- Single slow: req=4'b0100, mode2=01 → grant_idx=2 one cycle later; LED high 50 cycles, low 50, repeating.
- Preemption hold: source 3 fast granted; source 0 requests at tick 3 → source 3 keeps the LED until tick 10, then grant_idx=0 with the pattern restarted in ON.
- Holder release: holder drops req mid-phase with no others pending → next edge LED=0, active=0. With source 1 pending instead, grant_idx=1 on the next edge.
- Code 3: LED pattern 20 on / 20 off twice, then 20 on / 100 off, repeating. Code 0 → LED=0, active=1.
- Mode change: holder switches slow→on at tick 4 → ignored until tick 10, then LED=1 steady.
